vector_rf: RTL and testbench
============================

Name: vector_rf

Overview:
Parametrised successor to the scalar register file. Holds NREGS vector registers of LANES x WIDTH bits and provides three combinational read ports and one lane-masked write port. Adds a write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard that raises a hazard stall for the issue stage. Sits between decode/issue (reads, issue marking) and writeback (writes, busy clear).

Parameters:
WIDTH, 16, bits per lane element
LANES, 4, elements per vector register
NREGS, 32, number of registers; ADDR_W = $clog2(NREGS)
ZERO_REG, 1, 1: register 0 reads all-zero, writes to it ignored, never busy
BYPASS, 1, 1: same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock
rst  in  1  reset
RS1/RS2/RS3  in  ADDR_W  read addresses
RD1/RD2/RD3  out  LANES*WIDTH  read data; lane i = bits [i*WIDTH +: WIDTH]
WE  in  1  write enable
WA  in  ADDR_W  write address
WD  in  LANES*WIDTH  write data
WMASK  in  LANES  per-lane write enable
ISSUE_EN  in  1  instruction issued; mark ISSUE_RD busy
ISSUE_RD  in  ADDR_W  destination of the issued instruction
USE1/USE2/USE3  in  1  RSx is a real source operand for hazard check
STALL  out  1  combinational: any used source busy and not resolved this cycle
BUSY  out  NREGS  scoreboard bits, registered

Behaviour:
- Single clock clk; reset is synchronous and active-high: rst sampled at posedge clk clears all registers and all BUSY bits; rst has priority over WE/ISSUE_EN in that cycle. After reset: RD1..3 = 0, BUSY = 0, STALL = 0.
- Reset mid-operation: pending busy bits are discarded; writes in the reset cycle are lost.
- Read: combinational, zero latency. Address >= NREGS (non-power-of-2 NREGS) reads 0. ZERO_REG=1 and RSx==0 reads 0.
- Write: at posedge when WE=1 and not rst, each lane i with WMASK[i]=1 takes WD lane i. Unmasked lanes hold. WA >= NREGS is ignored. WA==0 is ignored when ZERO_REG=1. WMASK=0 writes nothing but still clears busy.
- Bypass (BYPASS=1): if WE=1 and WA==RSx (valid, non-zero-reg), lanes with WMASK=1 on RDx show WD; other lanes show the stored value. BYPASS=0: RDx shows the stored value until the edge.
- Scoreboard, per register r, next-state priority:
  - rst -> 0
  - ISSUE_EN and ISSUE_RD==r -> 1 (a new producer wins over a simultaneous writeback to the same r)
  - WE and WA==r -> 0
  - otherwise hold
  - ZERO_REG=1: bit 0 is constantly 0.
- STALL = OR over x of (USEx and BUSY[RSx] and not (BYPASS and WE and WA==RSx)). It does not depend on the ISSUE_* ports in the same cycle (no combinational loop through issue).
- Multiple read ports may address the same register; all return identical data.

Decomposition:
- Package vrf_pkg: default WIDTH/LANES/NREGS constants, typedef lane_t = logic[WIDTH-1:0], typedef vec_t = lane_t [LANES-1:0], and helper function lane_merge(old, new, mask).
- Storage is an array of vec_t, not discrete registers.
- One natural sub-module, vrf_read_port (address decode, zero-reg, range check, bypass merge), instantiated three times.
- Scoreboard stays inline.

Test Plan:
1. rst=1 one cycle, then RS1=5 -> RD1=0, BUSY=0, STALL=0.
2. WE=1, WA=3, WD=64'h0004_0003_0002_0001, WMASK=4'b1111; next cycle WMASK=4'b0101, WD=64'hFFFF_FFFF_FFFF_FFFF -> R3 reads 64'h0004_FFFF_0002_FFFF.
3. Same cycle as case 2 second write, RS2=3 with BYPASS=1 -> RD2=64'h0004_FFFF_0002_FFFF combinationally; BYPASS=0 -> RD2=64'h0004_0003_0002_0001 until the edge.
4. ISSUE_EN, ISSUE_RD=7; next cycle RS1=7, USE1=1 -> STALL=1; with USE1=0 -> STALL=0. Then WE, WA=7 -> STALL=0 that cycle (bypass), BUSY[7]=0 after the edge.
5. ISSUE_EN, ISSUE_RD=9 and WE, WA=9 in the same cycle with BUSY[9]=1 -> BUSY[9] stays 1. Write WA=0, WD=all-ones with ZERO_REG=1 -> RD of reg 0 = 0, BUSY[0]=0.
6. BUSY[4]=1 and R4=0x1234, assert rst with WE, WA=4 in the same cycle -> R4=0 and BUSY[4]=0 after the edge.

Source files
------------

// File: rtl/vrf_pkg.sv
// vrf_pkg: default geometry, lane/vector types and the lane-masked merge helper.
package vrf_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_LANES = 4;
    localparam int DEF_NREGS = 32;
    typedef logic [DEF_WIDTH-1:0] lane_t;
    typedef lane_t [DEF_LANES-1:0] vec_t;
    function automatic vec_t lane_merge(vec_t old_v, vec_t new_v, logic [DEF_LANES-1:0] mask);
        vec_t m;
        for (int i = 0; i < DEF_LANES; i++) m[i] = mask[i] ? new_v[i] : old_v[i];
        return m;
    endfunction
endpackage

// File: rtl/vrf_read_port.sv
// vrf_read_port: one combinational read port with range check, zero register and write bypass.
module vrf_read_port
    import vrf_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic [ADDR_W-1:0]    addr,
    input  vec_t                 mem [NREGS],
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wa,
    input  vec_t                 wd,
    input  logic [DEF_LANES-1:0] wmask,
    output vec_t                 data
);
    logic valid, hit;
    vec_t stored;
    assign valid  = 32'(addr) < NREGS && !(ZERO_REG != 0 && addr == '0);
    assign stored = valid ? mem[addr] : '0;
    // a valid read address matching the write address implies a valid write
    assign hit    = BYPASS != 0 && valid && we && wa == addr;
    assign data   = hit ? lane_merge(stored, wd, wmask) : stored;
endmodule

// File: rtl/vector_rf.sv
// vector_rf: vector register file with three read ports, lane-masked write,
// write-to-read bypass, optional zero register and a busy scoreboard for issue stalls.
module vector_rf
    import vrf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int NREGS = DEF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      RS1,
    input  logic [ADDR_W-1:0]      RS2,
    input  logic [ADDR_W-1:0]      RS3,
    output logic [LANES*WIDTH-1:0] RD1,
    output logic [LANES*WIDTH-1:0] RD2,
    output logic [LANES*WIDTH-1:0] RD3,
    input  logic                   WE,
    input  logic [ADDR_W-1:0]      WA,
    input  logic [LANES*WIDTH-1:0] WD,
    input  logic [LANES-1:0]       WMASK,
    input  logic                   ISSUE_EN,
    input  logic [ADDR_W-1:0]      ISSUE_RD,
    input  logic                   USE1,
    input  logic                   USE2,
    input  logic                   USE3,
    output logic                   STALL,
    output logic [NREGS-1:0]       BUSY
);
    vec_t mem [NREGS];
    vec_t wd, rd1, rd2, rd3;
    logic wa_ok;
    logic [NREGS-1:0] busy_d;
    assign wd    = WD;
    assign wa_ok = WE && 32'(WA) < NREGS && !(ZERO_REG != 0 && WA == '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else if (wa_ok) begin
            mem[WA] <= lane_merge(mem[WA], wd, WMASK);
        end
    end
    vrf_read_port #(.NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp1 (
        .addr(RS1), .mem(mem), .we(WE), .wa(WA), .wd(wd), .wmask(WMASK), .data(rd1)
    );
    vrf_read_port #(.NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp2 (
        .addr(RS2), .mem(mem), .we(WE), .wa(WA), .wd(wd), .wmask(WMASK), .data(rd2)
    );
    vrf_read_port #(.NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp3 (
        .addr(RS3), .mem(mem), .we(WE), .wa(WA), .wd(wd), .wmask(WMASK), .data(rd3)
    );
    assign RD1 = rd1;
    assign RD2 = rd2;
    assign RD3 = rd3;
    // issue is applied after writeback so a new producer wins on the same register
    always_comb begin
        busy_d = BUSY;
        for (int r = 0; r < NREGS; r++) begin
            if (WE && 32'(WA) == r) busy_d[r] = 1'b0;
            if (ISSUE_EN && 32'(ISSUE_RD) == r) busy_d[r] = 1'b1;
        end
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) BUSY <= '0;
        else BUSY <= busy_d;
    end
    function automatic logic src_stall(logic u, logic [ADDR_W-1:0] rs, logic [NREGS-1:0] busy,
                                       logic we, logic [ADDR_W-1:0] wa);
        return u && 32'(rs) < NREGS && busy[rs] && !(BYPASS != 0 && we && wa == rs);
    endfunction
    assign STALL = src_stall(USE1, RS1, BUSY, WE, WA) || src_stall(USE2, RS2, BUSY, WE, WA)
                || src_stall(USE3, RS3, BUSY, WE, WA);
endmodule

// File: tb/tb_vector_rf.sv
// tb_vector_rf: directed stimulus with a queue-based scoreboard checked at each falling edge.
module tb_vector_rf;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1, rs2, rs3, wa, issue_rd;
    logic we, issue_en, use1, use2, use3;
    logic [63:0] wd;
    logic [3:0] wmask;
    logic [63:0] rd1, rd2, rd3, nb_rd1, nb_rd2, nb_rd3, z_rd1, z_rd2, z_rd3;
    logic stall, nb_stall, z_stall;
    logic [31:0] busy, nb_busy;
    logic [23:0] z_busy;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } item_t;
    item_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_rf dut (
        .clk(clk), .rst(rst), .RS1(rs1), .RS2(rs2), .RS3(rs3), .RD1(rd1), .RD2(rd2), .RD3(rd3),
        .WE(we), .WA(wa), .WD(wd), .WMASK(wmask), .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd),
        .USE1(use1), .USE2(use2), .USE3(use3), .STALL(stall), .BUSY(busy)
    );
    vector_rf #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .RS1(rs1), .RS2(rs2), .RS3(rs3), .RD1(nb_rd1), .RD2(nb_rd2), .RD3(nb_rd3),
        .WE(we), .WA(wa), .WD(wd), .WMASK(wmask), .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd),
        .USE1(use1), .USE2(use2), .USE3(use3), .STALL(nb_stall), .BUSY(nb_busy)
    );
    vector_rf #(.NREGS(24)) dut_z (
        .clk(clk), .rst(rst), .RS1(rs1), .RS2(rs2), .RS3(rs3), .RD1(z_rd1), .RD2(z_rd2), .RD3(z_rd3),
        .WE(we), .WA(wa), .WD(wd), .WMASK(wmask), .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd),
        .USE1(use1), .USE2(use2), .USE3(use3), .STALL(z_stall), .BUSY(z_busy)
    );

    function automatic logic [63:0] actual(int k);
        case (k)
            0: return rd1;
            1: return rd2;
            2: return rd3;
            3: return {63'd0, stall};
            4: return {32'd0, busy};
            5: return nb_rd2;
            6: return {63'd0, nb_stall};
            default: return z_rd1;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t it;
            logic [63:0] a;
            it = q.pop_front();
            a = actual(it.kind);
            checks++;
            if (a !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, a, it.exp);
            end
        end
    end

    task automatic expect_v(int k, logic [63:0] v, string n);
        q.push_back('{kind: k, exp: v, name: n});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; wmask = '0; issue_en = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0; rs3 = '0; use1 = 1'b0; use2 = 1'b0; use3 = 1'b0;
        tick;
        rst = 1'b0;
        rs1 = 5'd5; use1 = 1'b1;
        expect_v(0, 64'd0, "reset_rd1");
        expect_v(4, 64'd0, "reset_busy");
        expect_v(3, 64'd0, "reset_stall");
        tick;
        use1 = 1'b0;
        we = 1'b1; wa = 5'd3; wd = 64'h0004_0003_0002_0001; wmask = 4'b1111; rs2 = 5'd3;
        expect_v(1, 64'h0004_0003_0002_0001, "bypass_full");
        expect_v(5, 64'd0, "nobypass_full");
        tick;
        wmask = 4'b0101; wd = 64'hFFFF_FFFF_FFFF_FFFF;
        expect_v(1, 64'h0004_FFFF_0002_FFFF, "bypass_masked");
        expect_v(5, 64'h0004_0003_0002_0001, "nobypass_masked");
        tick;
        we = 1'b0; rs1 = 5'd3; rs3 = 5'd3;
        expect_v(0, 64'h0004_FFFF_0002_FFFF, "masked_rd1");
        expect_v(2, 64'h0004_FFFF_0002_FFFF, "masked_rd3");
        expect_v(5, 64'h0004_FFFF_0002_FFFF, "nobypass_after_edge");
        tick;
        we = 1'b1; wa = 5'd30; wd = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 4'b1111; rs1 = 5'd30;
        expect_v(7, 64'd0, "range_bypass");
        expect_v(0, 64'hFFFF_FFFF_FFFF_FFFF, "r30_bypass");
        tick;
        we = 1'b0;
        expect_v(7, 64'd0, "range_stored");
        expect_v(0, 64'hFFFF_FFFF_FFFF_FFFF, "r30_stored");
        tick;
        issue_en = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; use1 = 1'b1;
        expect_v(3, 64'd0, "stall_issue_same_cycle");
        tick;
        issue_en = 1'b0;
        expect_v(3, 64'd1, "stall_busy");
        expect_v(6, 64'd1, "nb_stall_busy");
        expect_v(4, 64'h80, "busy7");
        tick;
        use1 = 1'b0;
        expect_v(3, 64'd0, "stall_unused");
        tick;
        use1 = 1'b1; we = 1'b1; wa = 5'd7; wd = 64'h1111_2222_3333_4444; wmask = 4'b1111;
        expect_v(3, 64'd0, "stall_resolved");
        expect_v(6, 64'd1, "nb_stall_unresolved");
        expect_v(4, 64'h80, "busy7_pre_wb");
        tick;
        we = 1'b0;
        expect_v(4, 64'd0, "busy7_cleared");
        expect_v(3, 64'd0, "stall_after_wb");
        expect_v(0, 64'h1111_2222_3333_4444, "r7_data");
        tick;
        use1 = 1'b0; issue_en = 1'b1; issue_rd = 5'd9;
        tick;
        we = 1'b1; wa = 5'd9; wd = 64'hAAAA_BBBB_CCCC_DDDD; rs2 = 5'd9;
        expect_v(4, 64'h200, "busy9_set");
        tick;
        we = 1'b0; issue_en = 1'b0;
        expect_v(4, 64'h200, "busy9_issue_wins");
        expect_v(1, 64'hAAAA_BBBB_CCCC_DDDD, "r9_data");
        tick;
        we = 1'b1; wa = 5'd9; wd = 64'd0; wmask = 4'b0000;
        expect_v(1, 64'hAAAA_BBBB_CCCC_DDDD, "mask0_bypass");
        expect_v(5, 64'hAAAA_BBBB_CCCC_DDDD, "mask0_nb");
        tick;
        we = 1'b0;
        expect_v(4, 64'd0, "mask0_clears_busy");
        expect_v(1, 64'hAAAA_BBBB_CCCC_DDDD, "mask0_keeps_data");
        tick;
        issue_en = 1'b1; issue_rd = 5'd0; we = 1'b1; wa = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF;
        wmask = 4'b1111; rs1 = 5'd0;
        expect_v(0, 64'd0, "zero_reg_bypass");
        tick;
        issue_en = 1'b0; we = 1'b0; use1 = 1'b1;
        expect_v(0, 64'd0, "zero_reg_read");
        expect_v(4, 64'd0, "zero_reg_busy");
        expect_v(3, 64'd0, "zero_reg_stall");
        tick;
        use1 = 1'b0; we = 1'b1; wa = 5'd4; wd = 64'h1234; issue_en = 1'b1; issue_rd = 5'd4; rs1 = 5'd4;
        expect_v(0, 64'h1234, "r4_bypass");
        tick;
        we = 1'b0; issue_en = 1'b0;
        expect_v(0, 64'h1234, "r4_stored");
        expect_v(4, 64'h10, "busy4");
        tick;
        rst = 1'b1; we = 1'b1; wa = 5'd4; wd = 64'h5555; issue_en = 1'b1; issue_rd = 5'd5;
        tick;
        rst = 1'b0; we = 1'b0; issue_en = 1'b0;
        expect_v(0, 64'd0, "r4_after_rst");
        expect_v(4, 64'd0, "busy_after_rst");
        expect_v(2, 64'd0, "r3_after_rst");
        tick;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
